// File: rtl/serial_port.sv
// serial_port: user-side endpoint of the board serial link.
// User bytes are queued in a TX FIFO and presented to the UART glue on
// txdata with a one-cycle txclk strobe; bytes from the UART glue are
// acknowledged with a one-cycle rxclk strobe and queued in an RX FIFO.
// Optional feature macro: SERIAL_PORT_ECHO_EN -- when defined, every
// received byte is also pushed into the TX FIFO on the same edge.

// Byte FIFO with show-ahead head (reads 0 while empty).
module serial_port_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic [4:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          full_s, empty_s, push_ok_s, pop_ok_s;

    assign full_s    = (cnt_q == 5'(DEPTH));
    assign empty_s   = (cnt_q == 5'd0);
    assign push_ok_s = push && !full_s;
    assign pop_ok_s  = pop && !empty_s;
    assign count     = cnt_q;
    assign head      = empty_s ? 8'h00 : mem_q[rd_ptr_q];

    // Next storage, pointer and occupancy values; rejected requests leave all state alone.
    always_comb begin
        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + 5'd1;
            2'b01:   cnt_d = cnt_q - 5'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO registers; reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 5'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module serial_port #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 3
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx_full,
    output logic [4:0] tx_count,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_empty,
    output logic [7:0] txdata,
    output logic       txclk,
    input  logic       txready,
    input  logic [7:0] rxdata,
    output logic       rxclk,
    input  logic       rxready
);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_LOAD   = 2'd1,
        T_STROBE = 2'd2,
        T_SETTLE = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_STROBE = 2'd1,
        R_SETTLE = 2'd2
    } rx_state_t;

    logic [1:0]    tx_sync_q, tx_sync_d;
    logic [1:0]    rx_sync_q, rx_sync_d;
    logic          txready_s, rxready_s;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]    txdata_q, txdata_d;
    logic          txclk_q, txclk_d;
    logic          tx_pop_s;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rxclk_q, rxclk_d;
    logic          rx_push_s, rx_accept_s;

    logic          tx_push_s;
    logic [7:0]    tx_push_data_s;
    logic [7:0]    tx_head_s;
    logic [4:0]    rx_count_s;
    logic          tx_empty_s, rx_full_s;

    serial_port_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (hz100),
        .rst       (reset),
        .push      (tx_push_s),
        .push_data (tx_push_data_s),
        .pop       (tx_pop_s),
        .head      (tx_head_s),
        .count     (tx_count)
    );

    serial_port_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (hz100),
        .rst       (reset),
        .push      (rx_push_s),
        .push_data (rxdata),
        .pop       (rd_en),
        .head      (rd_data),
        .count     (rx_count_s)
    );

    assign tx_full    = (tx_count == 5'(DEPTH));
    assign tx_empty_s = (tx_count == 5'd0);
    assign rx_full_s  = (rx_count_s == 5'(DEPTH));
    assign rx_empty   = (rx_count_s == 5'd0);
    assign txready_s  = tx_sync_q[1];
    assign rxready_s  = rx_sync_q[1];
    assign txdata     = txdata_q;
    assign txclk      = txclk_q;
    assign rxclk      = rxclk_q;

`ifdef SERIAL_PORT_ECHO_EN
    // Echo: a user write owns the TX FIFO write port, so RX capture waits for a free cycle.
    assign rx_accept_s    = rxready_s && !rx_full_s && !tx_full && !wr_en;
    assign tx_push_s      = wr_en || rx_push_s;
    assign tx_push_data_s = wr_en ? wr_data : rxdata;
`else
    assign rx_accept_s    = rxready_s && !rx_full_s;
    assign tx_push_s      = wr_en;
    assign tx_push_data_s = wr_data;
`endif

    // Two-flop synchronizers for the UART handshake inputs.
    always_comb begin
        tx_sync_d = {tx_sync_q[0], txready};
        rx_sync_d = {rx_sync_q[0], rxready};
    end

    // TX FSM: pop into txdata, strobe one cycle later, then hold off for the settle count.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        txdata_d   = txdata_q;
        txclk_d    = 1'b0;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!tx_empty_s && txready_s) begin
                    tx_state_d = T_LOAD;
                    tx_pop_s   = 1'b1;
                    txdata_d   = tx_head_s;
                end else begin
                    tx_state_d = T_IDLE;
                end
            end
            T_LOAD: begin
                tx_state_d = T_STROBE;
                txclk_d    = 1'b1;
            end
            T_STROBE: begin
                tx_state_d = T_SETTLE;
                tx_cnt_d   = CW'(SETTLE);
            end
            T_SETTLE: begin
                tx_cnt_d = tx_cnt_q - CW'(1);
                if (tx_cnt_q == CW'(1)) begin
                    tx_state_d = T_IDLE;
                end else begin
                    tx_state_d = T_SETTLE;
                end
            end
            default: begin
                tx_state_d = T_IDLE;
                tx_cnt_d   = '0;
            end
        endcase
    end

    // RX FSM: capture and acknowledge together, then settle so the synchronized rxready can fall.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rxclk_d    = 1'b0;
        rx_push_s  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_accept_s) begin
                    rx_state_d = R_STROBE;
                    rx_push_s  = 1'b1;
                    rxclk_d    = 1'b1;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_STROBE: begin
                rx_state_d = R_SETTLE;
                rx_cnt_d   = CW'(SETTLE);
            end
            R_SETTLE: begin
                rx_cnt_d = rx_cnt_q - CW'(1);
                if (rx_cnt_q == CW'(1)) begin
                    rx_state_d = R_IDLE;
                end else begin
                    rx_state_d = R_SETTLE;
                end
            end
            default: begin
                rx_state_d = R_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset drops any strobe at once and idles both directions.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            tx_sync_q  <= 2'b00;
            rx_sync_q  <= 2'b00;
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            txdata_q   <= 8'h00;
            txclk_q    <= 1'b0;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rxclk_q    <= 1'b0;
        end else begin
            tx_sync_q  <= tx_sync_d;
            rx_sync_q  <= rx_sync_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            txdata_q   <= txdata_d;
            txclk_q    <= txclk_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rxclk_q    <= rxclk_d;
        end
    end
endmodule

// File: tb/tb_serial_port.sv
// Testbench for serial_port: scenario tasks with inline checks against a
// queue-based model of the expected byte streams.
`timescale 1ns/1ps
module tb_serial_port;
    localparam int DEPTH  = 8;
    localparam int SETTLE = 3;
    localparam int HALF   = 5000;   // 10 us clock, so a 1 us UART reaction fits within a cycle

    logic       hz100 = 1'b0;
    logic       reset, wr_en, rd_en, txready, rxready;
    logic [7:0] wr_data, rxdata, rd_data, txdata;
    logic       tx_full, rx_empty, txclk, rxclk;
    logic [4:0] tx_count;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         rx_strobes = 0;
    logic [7:0] tx_seen[$];
    int         tx_cyc[$];

    serial_port #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .hz100(hz100), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .tx_full(tx_full), .tx_count(tx_count), .rd_en(rd_en), .rd_data(rd_data),
        .rx_empty(rx_empty), .txdata(txdata), .txclk(txclk), .txready(txready),
        .rxdata(rxdata), .rxclk(rxclk), .rxready(rxready)
    );

    always #HALF hz100 = ~hz100;

    // Cycle counter for strobe spacing.
    always @(posedge hz100) cyc <= cyc + 1;

    // Strobe monitor sampled on the falling edge.
    always @(negedge hz100) begin
        if (txclk === 1'b1) begin
            tx_seen.push_back(txdata);
            tx_cyc.push_back(cyc);
        end
        if (rxclk === 1'b1) rx_strobes <= rx_strobes + 1;
    end

    // Watchdog.
    initial begin
        #50000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hz100);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; txready = 1'b0; rxready = 1'b0;
        wr_data = 8'h00; rxdata = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
        tx_seen.delete();
        tx_cyc.delete();
    endtask

    // UART model: present a byte, wait for the acknowledge, drop rxready 1 us later.
    task automatic uart_send(input logic [7:0] b, output int lat, output logic empty_at);
        rxdata = b; rxready = 1'b1; lat = 0; empty_at = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (rxclk === 1'b1) begin
                lat = k;
                empty_at = rx_empty;
                break;
            end
        end
        #1000;
        rxready = 1'b0;
        tick(6);
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b1; wr_data = 8'hA5; rd_en = 1'b1; txready = 1'b1;
        rxready = 1'b1; rxdata = 8'h3C;
        tick(3);
        checks++; if (txdata !== 8'h00) begin failures++; $display("FAIL reset_txdata got=%0h exp=0", txdata); end
        checks++; if (txclk !== 1'b0) begin failures++; $display("FAIL reset_txclk got=%0b exp=0", txclk); end
        checks++; if (rxclk !== 1'b0) begin failures++; $display("FAIL reset_rxclk got=%0b exp=0", rxclk); end
        checks++; if (tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full got=%0b exp=0", tx_full); end
        checks++; if (tx_count !== 5'd0) begin failures++; $display("FAIL reset_tx_count got=%0d exp=0", tx_count); end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_rx_empty got=%0b exp=1", rx_empty); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        do_reset();
        checks++; if (rx_empty !== 1'b1 || tx_count !== 5'd0) begin failures++; $display("FAIL post_reset_idle rx_empty=%0b tx_count=%0d exp 1/0", rx_empty, tx_count); end
    endtask

    task automatic test_tx_path();
        do_reset();
        txready = 1'b1;
        tick(3);
        wr_en = 1'b1; wr_data = 8'h41;
        tick(1);
        wr_en = 1'b0;
        checks++; if (tx_count !== 5'd1 || txclk !== 1'b0) begin failures++; $display("FAIL tx_after_push count=%0d txclk=%0b exp 1/0", tx_count, txclk); end
        tick(1);
        checks++; if (txdata !== 8'h41) begin failures++; $display("FAIL tx_data_latency got=%0h exp=41", txdata); end
        checks++; if (tx_count !== 5'd0 || txclk !== 1'b0) begin failures++; $display("FAIL tx_load count=%0d txclk=%0b exp 0/0", tx_count, txclk); end
        tick(1);
        checks++; if (txclk !== 1'b1) begin failures++; $display("FAIL tx_strobe_high got=%0b exp=1", txclk); end
        tick(1);
        checks++; if (txclk !== 1'b0) begin failures++; $display("FAIL tx_strobe_low got=%0b exp=0", txclk); end
        tick(10);
        checks++; if (tx_seen.size() != 1 || tx_seen[0] !== 8'h41) begin failures++; $display("FAIL tx_single_strobe n=%0d exp 1 strobe of 41", tx_seen.size()); end
        checks++; if (txdata !== 8'h41) begin failures++; $display("FAIL tx_data_hold got=%0h exp=41", txdata); end
    endtask

    task automatic check_tx_stream(input string name, input logic [7:0] exp[$]);
        int n;
        n = exp.size();
        for (int k = 0; k < 400 && tx_seen.size() < n; k++) tick(1);
        tick(20);
        checks++; if (tx_seen.size() != n) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, tx_seen.size(), n); end
        for (int i = 0; i < n && i < tx_seen.size(); i++) begin
            checks++; if (tx_seen[i] !== exp[i]) begin failures++; $display("FAIL %s_byte%0d got=%0h exp=%0h", name, i, tx_seen[i], exp[i]); end
            if (i > 0) begin
                checks++; if (tx_cyc[i] - tx_cyc[i-1] < 3 + SETTLE) begin failures++; $display("FAIL %s_gap%0d got=%0d exp>=%0d", name, i, tx_cyc[i] - tx_cyc[i-1], 3 + SETTLE); end
            end
        end
    endtask

    task automatic test_tx_fill();
        logic [7:0] exp[$];
        do_reset();
        txready = 1'b0;
        tick(3);
        for (int i = 0; i <= DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            if (exp.size() < DEPTH) exp.push_back(8'(i));
            tick(1);
        end
        wr_en = 1'b0;
        checks++; if (tx_full !== 1'b1) begin failures++; $display("FAIL fill_tx_full got=%0b exp=1", tx_full); end
        checks++; if (tx_count !== 5'(DEPTH)) begin failures++; $display("FAIL fill_tx_count got=%0d exp=%0d", tx_count, DEPTH); end
        tick(5);
        checks++; if (tx_seen.size() != 0) begin failures++; $display("FAIL fill_no_strobe got=%0d exp=0", tx_seen.size()); end
        txready = 1'b1;
        check_tx_stream("fill", exp);
        checks++; if (tx_count !== 5'd0 || tx_full !== 1'b0) begin failures++; $display("FAIL fill_drained count=%0d full=%0b exp 0/0", tx_count, tx_full); end
    endtask

    task automatic test_random_tx();
        for (int r = 0; r < 3; r++) begin
            logic [7:0] exp[$];
            int n;
            logic [7:0] b;
            do_reset();
            n = $urandom_range(DEPTH, 1);
            for (int i = 0; i < n; i++) begin
                txready = 1'($urandom_range(1, 0));
                b = 8'($urandom);
                wr_en = 1'b1; wr_data = b;
                exp.push_back(b);
                tick(1);
                wr_en = 1'b0;
                tick($urandom_range(3, 0));
            end
            txready = 1'b1;
            check_tx_stream("rand_tx", exp);
        end
    endtask

    task automatic test_rx_path();
        int lat, base;
        logic e;
        do_reset();
        base = rx_strobes;
        uart_send(8'h5A, lat, e);
        checks++; if (lat != 3) begin failures++; $display("FAIL rx_latency got=%0d exp=3", lat); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL rx_empty_with_rxclk got=%0b exp=0", e); end
        checks++; if (rx_strobes - base != 1) begin failures++; $display("FAIL rx_one_strobe got=%0d exp=1", rx_strobes - base); end
        checks++; if (rd_data !== 8'h5A || rx_empty !== 1'b0) begin failures++; $display("FAIL rx_head data=%0h empty=%0b exp 5a/0", rd_data, rx_empty); end
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        checks++; if (rx_empty !== 1'b1 || rd_data !== 8'h00) begin failures++; $display("FAIL rx_after_pop empty=%0b data=%0h exp 1/0", rx_empty, rd_data); end
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        checks++; if (rx_empty !== 1'b1 || rd_data !== 8'h00) begin failures++; $display("FAIL rx_pop_empty empty=%0b data=%0h exp 1/0", rx_empty, rd_data); end
    endtask

    task automatic test_rx_backpressure();
        logic [7:0] q[$];
        logic [7:0] b, extra;
        int lat, base, got;
        logic e;
        do_reset();
        base = rx_strobes;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            uart_send(b, lat, e);
            q.push_back(b);
        end
        checks++; if (rx_strobes - base != DEPTH) begin failures++; $display("FAIL bp_fill_strobes got=%0d exp=%0d", rx_strobes - base, DEPTH); end
        checks++; if (rd_data !== q[0]) begin failures++; $display("FAIL bp_head got=%0h exp=%0h", rd_data, q[0]); end
        extra = 8'($urandom);
        rxdata = extra; rxready = 1'b1;
        tick(30);
        checks++; if (rx_strobes - base != DEPTH) begin failures++; $display("FAIL bp_full_no_rxclk got=%0d exp=%0d", rx_strobes - base, DEPTH); end
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        void'(q.pop_front());
        got = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (rxclk === 1'b1) begin got = 1; break; end
        end
        #1000;
        rxready = 1'b0;
        q.push_back(extra);
        tick(10);
        checks++; if (got != 1 || rx_strobes - base != DEPTH + 1) begin failures++; $display("FAIL bp_release_strobes got=%0d exp=%0d", rx_strobes - base, DEPTH + 1); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (rd_data !== q[i]) begin failures++; $display("FAIL bp_drain%0d got=%0h exp=%0h", i, rd_data, q[i]); end
            rd_en = 1'b1; tick(1); rd_en = 1'b0;
        end
        checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL bp_drained_empty got=%0b exp=1", rx_empty); end
    endtask

    task automatic test_reset_mid_strobe();
        int got, n0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom); tick(1);
        end
        wr_en = 1'b0;
        txready = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (txclk === 1'b1) begin got = 1; break; end
        end
        checks++; if (got != 1) begin failures++; $display("FAIL mid_strobe_reached got=%0d exp=1", got); end
        #100;
        reset = 1'b1;
        #1;
        checks++; if (txclk !== 1'b0) begin failures++; $display("FAIL mid_reset_txclk got=%0b exp=0", txclk); end
        checks++; if (tx_count !== 5'd0 || txdata !== 8'h00) begin failures++; $display("FAIL mid_reset_state count=%0d data=%0h exp 0/0", tx_count, txdata); end
        n0 = tx_seen.size();
        tick(2);
        reset = 1'b0;
        tick(30);
        checks++; if (tx_seen.size() != n0 || tx_count !== 5'd0) begin failures++; $display("FAIL mid_reset_no_more strobes=%0d count=%0d exp %0d/0", tx_seen.size(), tx_count, n0); end
    endtask

    task automatic test_echo();
        int lat;
        logic e;
`ifdef SERIAL_PORT_ECHO_EN
        int got;
        do_reset();
        txready = 1'b1;
        tick(3);
        uart_send(8'h33, lat, e);
        checks++; if (lat != 3) begin failures++; $display("FAIL echo_rx_latency got=%0d exp=3", lat); end
        tick(10);
        checks++; if (rd_data !== 8'h33) begin failures++; $display("FAIL echo_rx_fifo got=%0h exp=33", rd_data); end
        checks++; if (tx_seen.size() != 1 || tx_seen[0] !== 8'h33) begin failures++; $display("FAIL echo_tx n=%0d exp 1 strobe of 33", tx_seen.size()); end
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        rxdata = 8'h33; rxready = 1'b1;
        tick(2);
        wr_en = 1'b1; wr_data = 8'h77;
        tick(1);
        wr_en = 1'b0;
        checks++; if (rxclk !== 1'b0) begin failures++; $display("FAIL echo_write_priority rxclk=%0b exp=0", rxclk); end
        got = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (rxclk === 1'b1) begin got = k + 1; break; end
        end
        #1000;
        rxready = 1'b0;
        checks++; if (got != 1) begin failures++; $display("FAIL echo_retry_cycle got=%0d exp=1", got); end
        tick(25);
        checks++; if (tx_seen.size() != 3) begin failures++; $display("FAIL echo_tx_total got=%0d exp=3", tx_seen.size()); end
        checks++; if (tx_seen.size() != 3 || tx_seen[1] !== 8'h77 || tx_seen[2] !== 8'h33) begin failures++; $display("FAIL echo_tx_order exp 77 then 33"); end
        checks++; if (rd_data !== 8'h33) begin failures++; $display("FAIL echo_rx_second got=%0h exp=33", rd_data); end
`else
        do_reset();
        txready = 1'b1;
        tick(3);
        uart_send(8'h33, lat, e);
        tick(10);
        checks++; if (tx_seen.size() != 0 || tx_count !== 5'd0) begin failures++; $display("FAIL no_echo strobes=%0d count=%0d exp 0/0", tx_seen.size(), tx_count); end
        checks++; if (rd_data !== 8'h33) begin failures++; $display("FAIL no_echo_rx got=%0h exp=33", rd_data); end
`endif
    endtask

    initial begin
        test_reset();
        test_tx_path();
        test_tx_fill();
        test_random_tx();
        test_rx_path();
        test_rx_backpressure();
        test_reset_mid_strobe();
        test_echo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
